// File: rtl/timer_param.sv
// Parametrised countdown timer for the alarm datapath.
// Free-running 2 Hz / 1 Hz prescaler, one-shot or auto-reload countdown.
module timer_param #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int VALUE_W     = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [VALUE_W-1:0] value,
    input  logic               start_timer,
    input  logic               pause,
    input  logic               abort,
    output logic               expired,
    output logic               one_hz_enable,
    output logic               two_hz_enable,
    output logic [VALUE_W-1:0] counter,
    output logic               busy
);

    localparam int HALF = CLK_HZ / 2;
    localparam int PW   = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [PW-1:0]      PRESC_MAX = PW'(HALF - 1);
    localparam logic [VALUE_W-1:0] CNT_ONE   = VALUE_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic               phase_q, phase_d;
    logic [VALUE_W-1:0] val_q, val_d;
    logic [VALUE_W-1:0] counter_q, counter_d;
    logic               expired_q, expired_d;

    logic               two_hz;
    logic               one_hz;
    logic               tick;

    // Enables decode from registers only, so they carry no input path.
    assign two_hz = (presc_q == PRESC_MAX);
    assign one_hz = two_hz & phase_q;
    assign tick   = one_hz & ~pause;

    // Prescaler next state: wraps at HALF-1, realigned by a start.
    always_comb begin
        presc_d = two_hz ? '0 : presc_q + PW'(1);
        phase_d = phase_q ^ two_hz;
        if (start_timer) begin
            presc_d = '0;
            phase_d = 1'b0;
        end
    end

    // Control next state: start beats abort, abort beats the tick.
    always_comb begin
        state_d   = state_q;
        val_d     = val_q;
        counter_d = counter_q;
        expired_d = expired_q;
        if (start_timer) begin
            val_d     = value;
            counter_d = value;
            if (value == '0) begin
                state_d   = S_DONE;
                expired_d = 1'b1;
            end else begin
                state_d   = S_RUN;
                expired_d = 1'b0;
            end
        end else if (abort) begin
            state_d   = S_IDLE;
            counter_d = '0;
            expired_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    expired_d = 1'b0;
                end
                S_RUN: begin
                    // In reload mode expired is a one-cycle pulse.
                    expired_d = 1'b0;
                    if (tick) begin
                        if (counter_q == CNT_ONE) begin
                            expired_d = 1'b1;
                            if (AUTO_RELOAD) begin
                                counter_d = val_q;
                            end else begin
                                counter_d = '0;
                                state_d   = S_DONE;
                            end
                        end else if (counter_q != '0) begin
                            counter_d = counter_q - CNT_ONE;
                        end
                    end
                end
                S_DONE: begin
                    counter_d = '0;
                    expired_d = 1'b1;
                end
                default: begin
                    state_d   = S_IDLE;
                    counter_d = '0;
                    expired_d = 1'b0;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            phase_q   <= 1'b0;
            val_q     <= '0;
            counter_q <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            phase_q   <= phase_d;
            val_q     <= val_d;
            counter_q <= counter_d;
            expired_q <= expired_d;
        end
    end

    assign expired       = expired_q;
    assign counter       = counter_q;
    assign busy          = (state_q == S_RUN);
    assign two_hz_enable = two_hz;
    assign one_hz_enable = one_hz;

endmodule

// File: tb/tb_timer_param.sv
// Self-checking bench for timer_param (CLK_HZ=8, VALUE_W=4).
// One-shot and auto-reload instances share stimulus; scoreboard queue.
module tb_timer_param;

    localparam int CLK_HZ = 8;
    localparam int VW     = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          pause;
    logic          abort;
    logic [VW-1:0] value;

    logic          exp0, one0, two0, busy0;
    logic [VW-1:0] cnt0;
    logic          exp1, one1, two1, busy1;
    logic [VW-1:0] cnt1;

    always #5 clk = ~clk;

    timer_param #(
        .CLK_HZ(CLK_HZ), .VALUE_W(VW), .AUTO_RELOAD(1'b0)
    ) u_os (
        .clock(clk), .reset(rst), .value(value),
        .start_timer(start), .pause(pause), .abort(abort),
        .expired(exp0), .one_hz_enable(one0),
        .two_hz_enable(two0), .counter(cnt0), .busy(busy0)
    );

    timer_param #(
        .CLK_HZ(CLK_HZ), .VALUE_W(VW), .AUTO_RELOAD(1'b1)
    ) u_ar (
        .clock(clk), .reset(rst), .value(value),
        .start_timer(start), .pause(pause), .abort(abort),
        .expired(exp1), .one_hz_enable(one1),
        .two_hz_enable(two1), .counter(cnt1), .busy(busy1)
    );

    typedef struct {
        int dut;
        int k;
        int sig;
        int val;
    } exp_t;

    exp_t  sbq[$];
    int    kk;
    int    checks = 0;
    int    fails  = 0;
    string sc     = "none";
    string nm[5]  = '{"counter", "expired", "busy", "one_hz", "two_hz"};

    task automatic chk(input string tag, input int got, input int want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    function automatic int obs(input int d, input int s);
        case (s)
            0: return d != 0 ? int'(cnt1) : int'(cnt0);
            1: return d != 0 ? int'(exp1) : int'(exp0);
            2: return d != 0 ? int'(busy1) : int'(busy0);
            3: return d != 0 ? int'(one1) : int'(one0);
            default: return d != 0 ? int'(two1) : int'(two0);
        endcase
    endfunction

    function automatic void push(input int d, input int k,
                                 input int s, input int v);
        exp_t e;
        e.dut = d;
        e.k   = k;
        e.sig = s;
        e.val = v;
        sbq.push_back(e);
    endfunction

    // base is the cycle where the prescaler sits at 0.
    function automatic void push_row(input int d, input int k,
                                     input int cnt, input int ex,
                                     input int bsy, input int base);
        int j;
        j = k - base;
        push(d, k, 0, cnt);
        push(d, k, 1, ex);
        push(d, k, 2, bsy);
        push(d, k, 3, (j >= 0 && j % 8 == 7) ? 1 : 0);
        push(d, k, 4, (j >= 0 && j % 4 == 3) ? 1 : 0);
    endfunction

    task automatic check_now();
        while (sbq.size() > 0 && sbq[0].k == kk) begin
            exp_t e;
            e = sbq.pop_front();
            chk($sformatf("%s.%s.%s@%0d", sc, e.dut != 0 ? "ar" : "os",
                          nm[e.sig], kk),
                obs(e.dut, e.sig), e.val);
        end
    endtask

    task automatic step();
        @(negedge clk);
        kk++;
        check_now();
    endtask

    task automatic go(input logic [VW-1:0] v, input logic ab);
        start = 1'b1;
        value = v;
        abort = ab;
        kk    = -1;
        step();
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic drain();
        chk({sc, ".drain"}, sbq.size(), 0);
        sbq.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        pause = 1'b0;
        abort = 1'b0;
        value = '0;

        sc = "idle";
        for (int k = 0; k <= 20; k++) begin
            push_row(0, k, 0, 0, 0, 0);
            push_row(1, k, 0, 0, 0, 0);
        end
        repeat (2) @(negedge clk);
        kk = 0;
        check_now();
        rst = 1'b0;
        while (kk < 20) step();
        drain();

        sc = "os3";
        for (int k = 0; k <= 30; k++) begin
            push_row(0, k, k < 24 ? 3 - k / 8 : 0,
                     k >= 24 ? 1 : 0, k < 24 ? 1 : 0, 0);
            push_row(1, k, 3 - (k / 8) % 3, k == 24 ? 1 : 0, 1, 0);
        end
        go(4'd3, 1'b0);
        while (kk < 30) step();
        drain();

        sc = "ar2";
        for (int k = 0; k <= 50; k++) begin
            push_row(0, k, k < 16 ? 2 - k / 8 : 0,
                     k >= 16 ? 1 : 0, k < 16 ? 1 : 0, 0);
            push_row(1, k, 2 - (k / 8) % 2,
                     (k > 0 && k % 16 == 0) ? 1 : 0, 1, 0);
        end
        go(4'd2, 1'b0);
        while (kk < 50) step();
        drain();

        sc = "pause";
        for (int k = 0; k <= 28; k++) begin
            push_row(0, k, k < 16 ? 2 : (k < 24 ? 1 : 0),
                     k >= 24 ? 1 : 0, k < 24 ? 1 : 0, 0);
            push_row(1, k, (k >= 16 && k < 24) ? 1 : 2,
                     k == 24 ? 1 : 0, 1, 0);
        end
        go(4'd2, 1'b0);
        while (kk < 28) begin
            step();
            if (kk == 5) pause = 1'b1;
            if (kk == 11) pause = 1'b0;
        end
        drain();

        sc = "abort";
        for (int k = 0; k <= 20; k++) begin
            push_row(0, k, k <= 12 ? 2 : 0, 0, k <= 12 ? 1 : 0, 0);
            push_row(1, k, k <= 12 ? 2 : 0, 0, k <= 12 ? 1 : 0, 0);
        end
        go(4'd2, 1'b0);
        while (kk < 20) begin
            step();
            if (kk == 5) pause = 1'b1;
            if (kk == 11) pause = 1'b0;
            if (kk == 12) abort = 1'b1;
            if (kk == 13) abort = 1'b0;
        end
        drain();

        sc = "st_ab";
        for (int k = 0; k <= 9; k++) begin
            push_row(0, k, k < 8 ? 3 : 2, 0, 1, 0);
            push_row(1, k, k < 8 ? 3 : 2, 0, 1, 0);
        end
        go(4'd3, 1'b1);
        while (kk < 9) step();
        drain();

        sc = "zero";
        for (int k = 0; k <= 5; k++) begin
            push_row(0, k, 0, 1, 0, 0);
            push_row(1, k, 0, 1, 0, 0);
        end
        go(4'd0, 1'b0);
        while (kk < 5) step();
        drain();

        sc = "restart";
        for (int k = 0; k <= 41; k++) begin
            if (k <= 10) begin
                push_row(0, k, k < 8 ? 3 : 2, 0, 1, 0);
                push_row(1, k, k < 8 ? 3 : 2, 0, 1, 0);
            end else begin
                push_row(0, k, (k - 11) < 24 ? 3 - (k - 11) / 8 : 0,
                         (k - 11) >= 24 ? 1 : 0,
                         (k - 11) < 24 ? 1 : 0, 11);
                push_row(1, k, 3 - ((k - 11) / 8) % 3,
                         (k - 11) == 24 ? 1 : 0, 1, 11);
            end
        end
        go(4'd3, 1'b0);
        while (kk < 41) begin
            step();
            if (kk == 2) value = 4'd9;
            if (kk == 10) begin
                start = 1'b1;
                value = 4'd3;
            end
            if (kk == 11) begin
                start = 1'b0;
                value = 4'd9;
            end
        end
        drain();

        sc = "rst_mid";
        for (int k = 0; k <= 30; k++) begin
            if (k <= 12) begin
                push_row(0, k, 3 - k / 8, 0, 1, 0);
                push_row(1, k, 3 - k / 8, 0, 1, 0);
            end else begin
                push_row(0, k, 0, 0, 0, 13);
                push_row(1, k, 0, 0, 0, 13);
            end
        end
        go(4'd3, 1'b0);
        while (kk < 30) begin
            step();
            if (kk == 12) rst = 1'b1;
            if (kk == 13) rst = 1'b0;
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
